// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 50;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte handshake bundle between uart_rx (master) and its consumer (slave).
// Parity_Err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] RX_Data_out;
  logic                      RX_Valid;
  logic                      RX_Ready;
  logic                      Frame_Err;
  logic                      Overrun;
`ifdef UART_RX_PARITY_EN
  logic                      Parity_Err;

  modport master (output RX_Data_out, RX_Valid, Frame_Err, Overrun, Parity_Err, input RX_Ready);
  modport slave  (input RX_Data_out, RX_Valid, Frame_Err, Overrun, Parity_Err, output RX_Ready);
`else
  modport master (output RX_Data_out, RX_Valid, Frame_Err, Overrun, input RX_Ready);
  modport slave  (input RX_Data_out, RX_Valid, Frame_Err, Overrun, output RX_Ready);
`endif
endinterface

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - clearable bit-period counter with half-bit and full-bit terminal counts.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 50,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tc,
  output logic full_tc
);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the full-bit count so the counter never wraps inside a state.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != FULL_CNT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tc = (cnt_q == HALF_CNT);
  assign full_tc = (cnt_q == FULL_CNT);
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames with a Parity_Err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 10
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      RX_Data_in,
  uart_rx_if.master rx_if
);
  logic                      sync_q, rx_s_q;
  rx_state_e                 state_q, state_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      done_q, done_d;
  logic                      frame_err_q, frame_err_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      byte_ok;
  logic                      half_tc, full_tc, timer_clear;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  // Restart the bit period on every state change and between data bits.
  assign timer_clear = (state_d != state_q) || (state_q == IDLE) || (state_q == DATA && full_tc);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .half_tc(half_tc),
    .full_tc(full_tc)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) state_d = START;
      START: if (half_tc) begin
        if (!rx_s_q) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (full_tc) begin
        shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (full_tc) begin
        par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
        state_d   = STOP;
      end
`endif
      STOP: if (full_tc) begin
        if (rx_s_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign byte_ok = done_q && !par_bad_q;
`else
  assign byte_ok = done_q;
`endif

  // Accept-and-complete in the same cycle reloads rather than clears.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = done_q && par_bad_q;
`endif
    if (byte_ok) begin
      if (!valid_q || rx_if.RX_Ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.RX_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= RX_Data_in;
      rx_s_q       <= sync_q;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.RX_Data_out = data_q;
  assign rx_if.RX_Valid    = valid_q;
  assign rx_if.Frame_Err   = frame_err_q;
  assign rx_if.Overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.Parity_Err  = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 8 clocks per bit.
// Covers UART_RX_PARITY_EN when that macro is defined for the build.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Rising edges from start-bit drive to the edge that loads RX_Valid.
  localparam int DONE_EDGES = CPB * (NBITS - 1) + 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_line = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RX_Data_in(rx_line),
    .rx_if     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cyc, ferr_cnt, ovr_cnt, perr_cnt, lat;
  logic [7:0] last_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.RX_Valid) begin
        valid_cyc++;
        last_data = bus.RX_Data_out;
      end
      if (bus.Frame_Err) ferr_cnt++;
      if (bus.Overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (bus.Parity_Err) perr_cnt++;
`endif
    end
  end

  task automatic clear_counts();
    valid_cyc = 0;
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    perr_cnt  = 0;
    last_data = 8'h00;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Caller is aligned to a falling edge; each bit lasts CPB clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
`else
    bits = {stop_bit, d, 1'b0};
`endif
    for (int i = 0; i < NBITS; i++) begin
      rx_line = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    bus.RX_Ready = 1'b0;
    clear_counts();
    lat = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_data", 32'(bus.RX_Data_out), 32'h00);
    check_eq("reset_valid", 32'(bus.RX_Valid), 32'h0);
    check_eq("reset_ferr", 32'(bus.Frame_Err), 32'h0);
    check_eq("reset_ovr", 32'(bus.Overrun), 32'h0);
    reset = 1'b0;
    idle(4 * CPB);

    // Single frame, consumer always ready
    clear_counts();
    bus.RX_Ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int n;
        n = 0;
        while (!bus.RX_Valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        lat = n;
      end
    join
    idle(2 * CPB);
    check_eq("a5_latency", 32'(lat), 32'(DONE_EDGES));
    check_eq("a5_valid_cycles", 32'(valid_cyc), 32'd1);
    check_eq("a5_data", 32'(last_data), 32'hA5);
    check_eq("a5_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("a5_ovr", 32'(ovr_cnt), 32'd0);

    // False start then a good frame
    clear_counts();
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    idle(4 * CPB);
    check_eq("false_start_valid", 32'(valid_cyc), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    check_eq("3c_valid_cycles", 32'(valid_cyc), 32'd1);
    check_eq("3c_data", 32'(last_data), 32'h3C);

    // Break: stop bit low and line held low for 20 bit-times
    clear_counts();
    send_frame(8'h55, 1'b0);
    rx_line = 1'b0;
    repeat (19 * CPB) @(negedge clk);
    idle(2 * CPB);
    check_eq("break_ferr", 32'(ferr_cnt), 32'd1);
    check_eq("break_valid", 32'(valid_cyc), 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(2 * CPB);
    check_eq("0f_data", 32'(last_data), 32'h0F);
    check_eq("0f_ferr", 32'(ferr_cnt), 32'd1);

    // Back-to-back with consumer stalled: overrun
    clear_counts();
    bus.RX_Ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2 * CPB);
    check_eq("ovr_valid", 32'(bus.RX_Valid), 32'h1);
    check_eq("ovr_data", 32'(bus.RX_Data_out), 32'h11);
    check_eq("ovr_count", 32'(ovr_cnt), 32'd1);
    bus.RX_Ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ovr_drain_valid", 32'(bus.RX_Valid), 32'h0);
    @(negedge clk);
    bus.RX_Ready = 1'b0;

    // Accept on the exact completion cycle of the second byte
    clear_counts();
    send_frame(8'h11, 1'b1);
    idle(CPB);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (DONE_EDGES - 1) @(posedge clk);
        @(negedge clk);
        bus.RX_Ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("swap_valid", 32'(bus.RX_Valid), 32'h1);
        check_eq("swap_data", 32'(bus.RX_Data_out), 32'h22);
        check_eq("swap_ovr", 32'(bus.Overrun), 32'h0);
        bus.RX_Ready = 1'b0;
      end
    join
    idle(2 * CPB);
    check_eq("swap_ovr_count", 32'(ovr_cnt), 32'd0);
    check_eq("swap_held", 32'(bus.RX_Data_out), 32'h22);

    // Reset during data bit 4 of 0xFF, with 0x22 still held
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (CPB * 5 + 2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_valid", 32'(bus.RX_Valid), 32'h0);
        check_eq("midreset_data", 32'(bus.RX_Data_out), 32'h00);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(2 * CPB);
    clear_counts();
    bus.RX_Ready = 1'b1;
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    check_eq("81_valid_cycles", 32'(valid_cyc), 32'd1);
    check_eq("81_data", 32'(last_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    par_flip = 1'b1;
    send_frame(8'h81, 1'b1);
    par_flip = 1'b0;
    idle(2 * CPB);
    check_eq("par_err_count", 32'(perr_cnt), 32'd1);
    check_eq("par_err_valid", 32'(valid_cyc), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
